pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush/stall control and a valid/ready handshake.
// Define PIPE_SKID_EN to add a skid entry that removes the out_ready_i -> in_ready_o path.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int KEEP_W = 70
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [KEEP_W-1:0] in_keep_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [KEEP_W-1:0] out_keep_o,
   output logic              out_flushed_o,
   output logic [1:0]        count_o
);

   logic              main_valid_q, main_valid_d;
   logic              flushed_q, flushed_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [KEEP_W-1:0] keep_q, keep_d;
   logic              push, pop;

   assign push = in_valid_i & in_ready_o;
   assign pop  = main_valid_q & out_ready_i & ~stall_i;

   assign out_valid_o   = main_valid_q;
   assign out_flushed_o = flushed_q;
   assign out_data_o    = data_q;
   assign out_keep_o    = keep_q;

`ifdef PIPE_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [KEEP_W-1:0] skid_keep_q, skid_keep_d;

   // Readiness depends only on registered state, so out_ready_i never reaches in_ready_o.
   assign in_ready_o = rst_ni & ~stall_i & ~skid_valid_q;
   assign count_o    = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
      main_valid_d = main_valid_q;
      flushed_d    = flushed_q;
      data_d       = data_q;
      keep_d       = keep_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_keep_d  = skid_keep_q;
      if (flush_i) begin
         main_valid_d = in_valid_i;
         flushed_d    = 1'b1;
         data_d       = '0;
         keep_d       = in_keep_i;
         skid_valid_d = 1'b0;
      end else if (!stall_i) begin
         if (pop && skid_valid_q) begin
            // Skid full means in_ready_o is low, so no push can coincide here.
            data_d       = skid_data_q;
            keep_d       = skid_keep_q;
            flushed_d    = 1'b0;
            skid_valid_d = 1'b0;
         end else if (push && (!main_valid_q || pop)) begin
            main_valid_d = 1'b1;
            flushed_d    = 1'b0;
            data_d       = in_data_i;
            keep_d       = in_keep_i;
         end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
            skid_keep_d  = in_keep_i;
         end else if (pop) begin
            main_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_keep_q  <= skid_keep_d;
      end
   end
`else
   // Single entry: a full stage can accept only when it is drained in the same cycle.
   assign in_ready_o = rst_ni & ~stall_i & (~main_valid_q | out_ready_i);
   assign count_o    = {1'b0, main_valid_q};

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
      main_valid_d = main_valid_q;
      flushed_d    = flushed_q;
      data_d       = data_q;
      keep_d       = keep_q;
      if (flush_i) begin
         main_valid_d = in_valid_i;
         flushed_d    = 1'b1;
         data_d       = '0;
         keep_d       = in_keep_i;
      end else if (!stall_i) begin
         if (push) begin
            main_valid_d = 1'b1;
            flushed_d    = 1'b0;
            data_d       = in_data_i;
            keep_d       = in_keep_i;
         end else if (pop) begin
            main_valid_d = 1'b0;
         end
      end
   end
`endif

   // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_valid_q <= 1'b0;
         flushed_q    <= 1'b0;
         data_q       <= '0;
         keep_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         flushed_q    <= flushed_d;
         data_q       <= data_d;
         keep_q       <= keep_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers both the default and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

   localparam int DATA_W = 64;
   localparam int KEEP_W = 70;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush, stall, in_valid, in_ready, out_valid, out_ready, out_flushed;
   logic [DATA_W-1:0] in_data, out_data;
   logic [KEEP_W-1:0] in_keep, out_keep;
   logic [1:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (flush),
      .stall_i      (stall),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .in_keep_i    (in_keep),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .out_keep_o   (out_keep),
      .out_flushed_o(out_flushed),
      .count_o      (count)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      flush = 0; stall = 0; in_valid = 0; out_ready = 1; in_data = '0; in_keep = '0;

      // Reset state
      step();
      step();
      check("rst_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_data", out_data, 0);
      check("rst_keep", out_keep, 0);
      check("rst_flushed", out_flushed, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Streaming 0..15, one per cycle
      in_valid = 1;
      for (int i = 0; i < 16; i++) begin
         in_data = DATA_W'(i);
         in_keep = KEEP_W'(i + 100);
         step();
         check("stream_data", out_data, i);
         check("stream_keep", out_keep, i + 100);
         check("stream_valid", out_valid, 1);
         check("stream_count", count, 1);
      end
      in_valid = 0;
      step();
      check("drain_valid", out_valid, 0);
      check("drain_count", count, 0);
      check("drain_data_held", out_data, 15);

      // Stall with a held entry
      in_valid = 1; out_ready = 0; in_data = 64'h55; in_keep = 70'h5;
      step();
      in_valid = 0;
      check("stall_pre_count", count, 1);
`ifndef PIPE_SKID_EN
      check("full_no_pop_ready", in_ready, 0);
`endif
      stall = 1; out_ready = 1;
      #1;
      check("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_data", out_data, 64'h55);
         check("stall_valid", out_valid, 1);
         check("stall_count", count, 1);
         check("stall_in_ready", in_ready, 0);
      end
      stall = 0;
      step();
      check("stall_release_valid", out_valid, 0);
      check("stall_release_count", count, 0);

      // Flush overrides stall
      out_ready = 0; in_valid = 1; in_data = 64'hAB; in_keep = 70'h100;
      step();
      check("flush_pre_data", out_data, 64'hAB);
      check("flush_pre_keep", out_keep, 70'h100);
      flush = 1; stall = 1; in_data = 64'hDEAD; in_keep = 70'h200;
      step();
      flush = 0; stall = 0; in_valid = 0;
      check("flush_data", out_data, 0);
      check("flush_keep", out_keep, 70'h200);
      check("flush_valid", out_valid, 1);
      check("flush_flushed", out_flushed, 1);
      check("flush_count", count, 1);
      out_ready = 1;
      step();
      check("flush_pop_valid", out_valid, 0);
      in_valid = 1; in_data = 64'h77; in_keep = 70'h7;
      step();
      in_valid = 0; out_ready = 0;
      check("after_flush_flushed", out_flushed, 0);
      check("after_flush_data", out_data, 64'h77);

      // Simultaneous push and pop at count 1
      in_valid = 1; out_ready = 1; in_data = 64'h88;
      step();
      check("pushpop_count", count, 1);
      check("pushpop_data", out_data, 64'h88);
      in_valid = 0;
      step();
      check("pushpop_drain", out_valid, 0);

`ifdef PIPE_SKID_EN
      // Skid fill and drain
      out_ready = 0; in_valid = 1; in_data = 64'h1;
      step();
      in_data = 64'h2;
      step();
      in_valid = 0;
      check("skid_count", count, 2);
      check("skid_in_ready", in_ready, 0);
      check("skid_head", out_data, 1);
      out_ready = 1;
      step();
      check("skid_pop1_data", out_data, 2);
      check("skid_pop1_count", count, 1);
      check("skid_pop1_ready", in_ready, 1);
      step();
      check("skid_pop2_valid", out_valid, 0);
      check("skid_pop2_count", count, 0);
`endif

      // Asynchronous reset mid-stream
      out_ready = 0; in_valid = 1; in_data = 64'h3;
      step();
`ifdef PIPE_SKID_EN
      in_data = 64'h4;
      step();
      check("pre_rst_count", count, 2);
`else
      check("pre_rst_count", count, 1);
`endif
      in_valid = 0;
      #1 rst_n = 0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_count", count, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_ready", in_ready, 0);
      step();
      rst_n = 1;
      out_ready = 1;
      step();
      check("post_rst2_valid", out_valid, 0);
      check("post_rst2_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
